pipe_adder: RTL



---
 rtl/pipe_adder_pkg.sv | 23 ++
 rtl/pipe_adder_if.sv | 39 +++
 rtl/pipe_adder_chunk_adder.sv | 31 +++
 rtl/pipe_adder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
//   stage_ctrl_t : width-independent control part of one pipeline stage record
//                  (valid, carry into the next chunk, MSBs of A and B').
//   nstages()    : number of pipeline stages (= latency in cycles).
//   cfg_ok()     : legality of a WIDTH/CHUNK pair, checked at elaboration.
package pipe_adder_pkg;

  typedef struct packed {
    logic valid;
    logic carry;
    logic a_msb;
    logic b_msb;
  } stage_ctrl_t;

  function automatic int nstages(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic bit cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (width >= 2) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result bundle interface of pipe_adder.
//   Producer side : in_valid, in_ready, in_a, in_b, in_cin, in_sub
//   Consumer side : out_valid, out_ready, out_sum, out_cout, out_ovf, out_zero
//   master        : the block driving operands and consuming results
//   slave         : the adder itself
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both 1. A source holds its data stable while valid=1 and ready=0; the
// adder's out_* never change while out_valid=1 and out_ready=0. in_ready may
// depend combinationally on out_valid/out_ready, but never on in_valid.
interface pipe_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

endinterface

// File: rtl/pipe_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder; one instance per pipeline stage.
//   a, b : CHUNK-bit addends
//   cin  : carry in
//   sum  : CHUNK-bit sum
//   cout : carry out of the top bit
module pipe_adder_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  // c[i] is the carry into bit i; c[CHUNK] leaves the chunk.
  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract unit with valid/ready on both sides.
// Stage k adds operand bits [k*CHUNK +: CHUNK] plus the carry from stage k-1;
// NSTAGES = WIDTH/CHUNK register stages, the last of which is the out_* set.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : pipe_adder_if slave modport
//              in_a/in_b/in_cin/in_sub operands, in_valid/in_ready handshake
//              out_sum/out_cout/out_ovf/out_zero results, out_valid/out_ready
//   in_sub=1 : A-B (B inverted, carry-in forced to 1, in_cin ignored)
//   out_cout : carry out of the MSB (for subtract, 1 = no borrow)
//   out_ovf  : two's-complement signed overflow
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic        clk,
  input logic        rst,
  pipe_adder_if.slave bus
);

  localparam int NSTAGES = nstages(WIDTH, CHUNK);
  // At least one entry so the array stays legal for a single-stage build.
  localparam int NREG    = (NSTAGES > 1) ? NSTAGES - 1 : 1;

  // Per-stage record. sum_lo collects finished chunks in place; a_hi/b_hi
  // shift right by CHUNK per stage so the next chunk is always at bit 0.
  typedef struct packed {
    stage_ctrl_t      ctrl;
    logic [WIDTH-1:0] sum_lo;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
  } stage_t;

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
    $error("pipe_adder: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  stage_t           head;
  stage_t           last;
  stage_t           src    [NSTAGES];
  stage_t           nxt    [NSTAGES];
  stage_t           pipe_q [NREG];

  // The whole pipeline moves in lock-step; it only stalls when a finished
  // result is waiting and the consumer refuses it. Bubbles are kept in place.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  assign b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;

  always_comb begin
    head            = '0;
    head.ctrl.valid = bus.in_valid;
    head.ctrl.carry = bus.in_sub | bus.in_cin;
    head.ctrl.a_msb = bus.in_a[WIDTH-1];
    head.ctrl.b_msb = b_eff[WIDTH-1];
    head.a_hi       = bus.in_a;
    head.b_hi       = b_eff;
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    logic [CHUNK-1:0] s;
    logic             co;
    stage_t           n;

    if (k == 0) begin : g_head
      assign src[k] = head;
    end else begin : g_link
      assign src[k] = pipe_q[k-1];
    end

    pipe_adder_chunk_adder #(
      .CHUNK (CHUNK)
    ) u_add (
      .a    (src[k].a_hi[CHUNK-1:0]),
      .b    (src[k].b_hi[CHUNK-1:0]),
      .cin  (src[k].ctrl.carry),
      .sum  (s),
      .cout (co)
    );

    always_comb begin
      n                            = src[k];
      n.sum_lo[k*CHUNK +: CHUNK]   = s;
      n.ctrl.carry                 = co;
      n.a_hi                       = src[k].a_hi >> CHUNK;
      n.b_hi                       = src[k].b_hi >> CHUNK;
    end

    assign nxt[k] = n;
  end

  assign last = nxt[NSTAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        pipe_q[i] <= '0;
      end
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_cout  <= 1'b0;
      bus.out_ovf   <= 1'b0;
    end else if (adv) begin
      for (int i = 0; i < NSTAGES - 1; i++) begin
        pipe_q[i] <= nxt[i];
      end
      bus.out_valid <= last.ctrl.valid;
      bus.out_sum   <= last.sum_lo;
      bus.out_cout  <= last.ctrl.carry;
      // Same-sign operands whose result sign differs have overflowed.
      bus.out_ovf   <= (last.ctrl.a_msb == last.ctrl.b_msb) &&
                       (last.sum_lo[WIDTH-1] != last.ctrl.a_msb);
    end
  end

  assign bus.out_zero = (bus.out_sum == '0);

endmodule
